// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device byte transmitter over open-drain clock/data pads.
// Optional device-silence timeout is built when PS2_TX_TIMEOUT_EN is defined.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int TIMEOUT_CYCLES = 750_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_START, S_SEND, S_ACK, S_WAIT_IDLE
  } state_t;

  state_t state, state_next;

  logic clk_s1, clk_s2, clk_prev;
  logic data_s1, data_s2;
  logic fall;

  logic [INH_W-1:0] inh_cnt;
  logic [3:0]       bit_cnt;
  logic [9:0]       shreg;
  logic             tx_bit;
  logic             nack;
  logic             done_r, error_r;
  logic             timeout_hit;

  // Pads idle high, so every stage reloads to 1 to avoid a false edge after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk_in;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      data_s1  <= ps2_data_in;
      data_s2  <= data_s1;
    end
  end

  assign fall = clk_prev & ~clk_s2;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;
  logic            active;

  assign active = (state == S_SEND) || (state == S_ACK) || (state == S_WAIT_IDLE);

  always_ff @(posedge clk) begin
    if (rst || !active || fall) begin
      to_cnt <= '0;
    end else if (to_cnt != TO_W'(TIMEOUT_CYCLES)) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign timeout_hit = active && !fall && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:      if (tx_valid) state_next = S_INHIBIT;
      S_INHIBIT:   if (inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) state_next = S_START;
      S_START:     state_next = S_SEND;
      S_SEND:      if (fall && bit_cnt == 4'd9) state_next = S_ACK;
      S_ACK:       if (fall) state_next = S_WAIT_IDLE;
      S_WAIT_IDLE: if (clk_s2 && data_s2) state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
    if (timeout_hit) state_next = S_IDLE;
  end

  always_comb begin
    tx_ready    = (state == S_IDLE);
    busy        = (state != S_IDLE);
    ps2_clk_oe  = (state == S_INHIBIT) || (state == S_START);
    ps2_data_oe = 1'b0;
    if (state == S_START)     ps2_data_oe = 1'b1;
    else if (state == S_SEND) ps2_data_oe = ~tx_bit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inh_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '1;
      tx_bit  <= 1'b0;
      nack    <= 1'b0;
      done_r  <= 1'b0;
      error_r <= 1'b0;
    end else begin
      done_r  <= 1'b0;
      error_r <= 1'b0;
      inh_cnt <= (state == S_INHIBIT) ? inh_cnt + 1'b1 : '0;
      case (state)
        S_IDLE: begin
          if (tx_valid) begin
            shreg   <= {1'b1, ~^tx_data, tx_data};
            bit_cnt <= '0;
          end
        end
        S_START: tx_bit <= 1'b0;
        S_SEND: begin
          // Each device falling edge presents the next bit; the stop bit refills from the top.
          if (fall) begin
            tx_bit  <= shreg[0];
            shreg   <= {1'b1, shreg[9:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        S_ACK: begin
          if (fall) begin
            nack    <= data_s2;
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        S_WAIT_IDLE: begin
          if (clk_s2 && data_s2) begin
            done_r  <= ~nack;
            error_r <= nack;
          end
        end
        default: ;
      endcase
      if (timeout_hit) begin
        done_r  <= 1'b0;
        error_r <= 1'b1;
      end
    end
  end

  assign tx_done  = done_r;
  assign tx_error = error_r;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - directed self-checking bench for ps2_host_tx with a PS/2 device model.
// The device clock is scaled to a fast half period to keep the run short.
module tb_ps2_host_tx;

  localparam int H = 30;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk_oe, ps2_data_oe;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, tx_done, tx_error;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       pad_clk, pad_data;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  assign pad_clk  = ~(ps2_clk_oe | dev_clk_low);
  assign pad_data = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk_in (pad_clk),
    .ps2_data_in(pad_data),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .tx_done    (tx_done),
    .tx_error   (tx_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_done)  done_cnt++;
    if (tx_error) err_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dev_pulse(output logic s);
    repeat (H) tick();
    dev_clk_low = 1'b1;
    repeat (H) tick();
    dev_clk_low = 1'b0;
    s = pad_data;
  endtask

  task automatic do_inhibit(output int n);
    n = 0;
    while (ps2_clk_oe === 1'b1 && n < 7000) begin
      n++;
      tick();
    end
  endtask

  // Samples at every device-visible rising edge, starting with the host releasing the clock.
  task automatic device_frame(input logic ack, output logic [10:0] s, output logic [2:0] lat);
    logic b;
    s[0] = pad_data;
    repeat (H) tick();
    dev_clk_low = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      lat[i] = ps2_data_oe;
    end
    repeat (H - 3) tick();
    dev_clk_low = 1'b0;
    s[1] = pad_data;
    for (int k = 2; k <= 10; k++) begin
      dev_pulse(b);
      s[k] = b;
    end
    repeat (H / 2) tick();
    dev_data_low = ack;
    repeat (H / 2) tick();
    dev_clk_low = 1'b1;
    repeat (H) tick();
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
  endtask

  task automatic wait_result(output int w);
    w = 0;
    while (!(tx_done || tx_error) && w < 500) begin
      w++;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tx_valid = 1'b1;
    tx_data = 8'h5A;
    repeat (3) tick();
    checks++; if (ps2_clk_oe !== 1'b0) begin failures++; $display("FAIL reset_clk_oe got %b want 0", ps2_clk_oe); end
    checks++; if (ps2_data_oe !== 1'b0) begin failures++; $display("FAIL reset_data_oe got %b want 0", ps2_data_oe); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (tx_done !== 1'b0 || tx_error !== 1'b0) begin failures++; $display("FAIL reset_pulses got done=%b err=%b want 0 0", tx_done, tx_error); end
    rst = 1'b0;
    tx_valid = 1'b0;
    tick();
    checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got %b want 1", tx_ready); end
    checks++; if (ps2_clk_oe !== 1'b0) begin failures++; $display("FAIL reset_no_accept got clk_oe=%b want 0", ps2_clk_oe); end
  endtask

  task automatic test_send(input string name, input logic [7:0] b, input logic [10:0] exp_s,
                           input logic ack, input logic chk_lat);
    int n, w, d0, e0;
    logic [10:0] s;
    logic [2:0]  lat;
    d0 = done_cnt;
    e0 = err_cnt;
    tx_data  = b;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    checks++; if (ps2_clk_oe !== 1'b1 || busy !== 1'b1 || tx_ready !== 1'b0) begin failures++; $display("FAIL %s accept got clk_oe=%b busy=%b ready=%b want 1 1 0", name, ps2_clk_oe, busy, tx_ready); end
    do_inhibit(n);
    checks++; if (n != 6001) begin failures++; $display("FAIL %s inhibit_len got %0d want 6001", name, n); end
    device_frame(ack, s, lat);
    checks++; if (s !== exp_s) begin failures++; $display("FAIL %s bits got %03h want %03h", name, s, exp_s); end
    if (chk_lat) begin
      checks++; if (lat !== 3'b011) begin failures++; $display("FAIL %s fall_latency got %b want 011", name, lat); end
    end
    wait_result(w);
    checks++; if (w >= 500) begin failures++; $display("FAIL %s result_timeout got %0d cycles want <500", name, w); end
    checks++; if (tx_done !== ack || tx_error !== ~ack || tx_ready !== 1'b1) begin failures++; $display("FAIL %s end_cycle got done=%b err=%b ready=%b want %b %b 1", name, tx_done, tx_error, tx_ready, ack, ~ack); end
    repeat (20) tick();
    checks++; if (done_cnt - d0 != (ack ? 1 : 0) || err_cnt - e0 != (ack ? 0 : 1)) begin failures++; $display("FAIL %s pulse_count got done=%0d err=%0d want %0d %0d", name, done_cnt - d0, err_cnt - e0, ack ? 1 : 0, ack ? 0 : 1); end
  endtask

  task automatic test_reset_midframe();
    int n, d0, e0;
    logic b;
    d0 = done_cnt;
    e0 = err_cnt;
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    do_inhibit(n);
    for (int k = 1; k <= 5; k++) dev_pulse(b);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin failures++; $display("FAIL midrst_oe got clk_oe=%b data_oe=%b want 0 0", ps2_clk_oe, ps2_data_oe); end
    checks++; if (tx_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL midrst_ready got ready=%b busy=%b want 1 0", tx_ready, busy); end
    repeat (200) tick();
    checks++; if (done_cnt != d0 || err_cnt != e0) begin failures++; $display("FAIL midrst_pulses got done=%0d err=%0d want 0 0", done_cnt - d0, err_cnt - e0); end
    test_send("resend_ff", 8'hFF, 11'h7FE, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    int n, w, d0, e0;
    logic [10:0] s;
    logic [2:0]  lat;
    d0 = done_cnt;
    e0 = err_cnt;
    tx_data  = 8'h12;
    tx_valid = 1'b1;
    tick();
    tx_data = 8'hA7;
    do_inhibit(n);
    checks++; if (n != 6001) begin failures++; $display("FAIL b2b_first_inhibit got %0d want 6001", n); end
    device_frame(1'b1, s, lat);
    checks++; if (s !== 11'h624) begin failures++; $display("FAIL b2b_first_bits got %03h want 624", s); end
    wait_result(w);
    checks++; if (tx_done !== 1'b1 || tx_ready !== 1'b1) begin failures++; $display("FAIL b2b_first_done got done=%b ready=%b want 1 1", tx_done, tx_ready); end
    tick();
    tx_valid = 1'b0;
    checks++; if (ps2_clk_oe !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL b2b_second_accept got clk_oe=%b busy=%b want 1 1", ps2_clk_oe, busy); end
    do_inhibit(n);
    checks++; if (n != 6001) begin failures++; $display("FAIL b2b_second_inhibit got %0d want 6001", n); end
    device_frame(1'b1, s, lat);
    checks++; if (s !== 11'h54E) begin failures++; $display("FAIL b2b_second_bits got %03h want 54e", s); end
    wait_result(w);
    repeat (20) tick();
    checks++; if (done_cnt - d0 != 2 || err_cnt != e0) begin failures++; $display("FAIL b2b_pulses got done=%0d err=%0d want 2 0", done_cnt - d0, err_cnt - e0); end
  endtask

`ifdef PS2_TX_TIMEOUT_EN
  task automatic test_timeout();
    int n, k;
    tx_data  = 8'hED;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    do_inhibit(n);
    k = 0;
    while (!tx_error && k < 800000) begin
      k++;
      tick();
    end
    checks++; if (k != 750000) begin failures++; $display("FAIL timeout_delay got %0d want 750000", k); end
    checks++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || tx_ready !== 1'b1) begin failures++; $display("FAIL timeout_release got clk_oe=%b data_oe=%b ready=%b want 0 0 1", ps2_clk_oe, ps2_data_oe, tx_ready); end
    tick();
  endtask
`endif

  initial begin
`ifdef PS2_TX_TIMEOUT_EN
    #(10 * 1_000_000);
`else
    #(10 * 200_000);
`endif
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_send("send_ed", 8'hED, 11'h7DA, 1'b1, 1'b1);
    test_send("send_01", 8'h01, 11'h402, 1'b1, 1'b0);
    test_send("send_00", 8'h00, 11'h600, 1'b1, 1'b0);
    test_send("nack_55", 8'h55, 11'h6AA, 1'b0, 1'b0);
    test_reset_midframe();
    test_back_to_back();
`ifdef PS2_TX_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: serialises one command byte onto the open-drain PS/2 clock/data pair (e.g. 0xED set-LEDs, 0xFF reset) toward the keyboard. It sits beside the keyboard receiver in the top level and shares the same `ps2_clk`/`ps2_data` pads through open-drain buffers. While `busy` is high the receiver output must be ignored. One frame is 1 start bit, 8 data bits LSB first, odd parity, stop bit, and a device ACK.

## Interface
- `INHIBIT_CYCLES`, 6000: clock-low request hold, in `clk` cycles (120 us at 50 MHz).
- `TIMEOUT_CYCLES`, 750_000: maximum gap between device clock edges (15 ms at 50 MHz).
- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  reset, synchronous and active-high.
- `ps2_clk_in`  in  1  raw pad level of the PS/2 clock.
- `ps2_data_in`  in  1  raw pad level of the PS/2 data.
- `ps2_clk_oe`  out  1  1 = drive the clock pad low; 0 = release.
- `ps2_data_oe`  out  1  1 = drive the data pad low; 0 = release.
- `tx_data`  in  8  byte to send.
- `tx_valid`  in  1  request; sampled only when `tx_ready` is high.
- `tx_ready`  out  1  high only in IDLE.
- `busy`  out  1  high in every state except IDLE.
- `tx_done`  out  1  one-cycle pulse: frame sent and ACK received.
- `tx_error`  out  1  one-cycle pulse: NACK, or timeout when enabled.

## Operation
- Input path:
  - 2-FF synchroniser on each pad input, followed by an edge register. All three stages reset to 1.
  - `fall` is one cycle wide: previous synchronised clock = 1 and current = 0.
- Accept:
  - On a `clk` edge with `tx_valid & tx_ready`, latch the shift register {stop=1, parity=~^tx_data, tx_data}.
  - Go to INHIBIT.
- States and transitions:
  - IDLE: both `oe`=0. `tx_ready`=1.
  - INHIBIT: `clk_oe`=1, `data_oe`=0 for exactly INHIBIT_CYCLES cycles, then START.
  - START: `clk_oe`=1, `data_oe`=1 (start bit) for 1 cycle, then SEND.
  - SEND: `clk_oe`=0, `data_oe` stays 1 until the first `fall`. Falls 1..10 each shift out the next bit with `data_oe` = ~bit, in the order d0..d7, parity, stop. Stop = 1, so the line is released. The 10th fall moves to ACK.
  - ACK: `data_oe`=0. On the 11th `fall`, sample synchronised data; 0 = ACK, 1 = NACK. Then go to WAIT_IDLE.
  - WAIT_IDLE: wait until synchronised clock and data are both 1. Then pulse `tx_done` (ACK) or `tx_error` (NACK) and go to IDLE.
- Exactly one of `tx_done`/`tx_error` pulses per accepted byte. Neither pulses on reset abort.
- `tx_valid` while busy is ignored; there is no queue.
- Reset mid-frame: the next cycle is IDLE with both `oe`=0, the synchroniser reloads to 1, and no pulse is produced.

## Timing
- Reset values:
  - `ps2_clk_oe`=0, `ps2_data_oe`=0, `busy`=0, `tx_done`=0, `tx_error`=0.
  - `tx_ready`=1 from the first cycle after `rst` deasserts. `rst` has priority over acceptance.
- Acceptance to `clk_oe`=1: 1 cycle.
- `clk_oe` is high for INHIBIT_CYCLES+1 cycles in total (INHIBIT plus START).
- Pad falling edge to `data_oe` update: 3 cycles (2 synchroniser + 1 register).
- `tx_done`/`tx_error` are registered, asserted for 1 cycle, and coincide with the return to IDLE. `tx_ready` rises in that same cycle.
- Counters:
  - INHIBIT counter width: clog2(INHIBIT_CYCLES+1).
  - Timeout counter width: clog2(TIMEOUT_CYCLES+1).
  - Bit counter: 4 bits, 0..11.
  - No counter wraps; each saturates or clears on state change.

## Configuration
- `PS2_TX_TIMEOUT_EN` defined:
  - The timeout counter clears on entry to SEND and on every `fall`.
  - In SEND, ACK or WAIT_IDLE, reaching TIMEOUT_CYCLES releases both `oe`, pulses `tx_error` and returns to IDLE in the same cycle.
- Undefined: no timeout logic; a silent device leaves the block in SEND indefinitely (`busy`=1). `TIMEOUT_CYCLES` is unused.

## Test plan
- Send 0xED with a device model clocking at 12.5 kHz and ACKing:
  - Required data sequence sampled at device rising edges: 0,1,0,1,1,0,1,1,1,1(parity),1(stop).
  - `clk_oe` high for 6001 cycles first.
  - Exactly one `tx_done`, no `tx_error`.
- Send 0x01: parity bit 0. Send 0x00: parity bit 1. Both end in `tx_done`.
- Device holds data high on the 11th clock (NACK) with 0x55: `tx_error` pulses once, `tx_done` never pulses, back to IDLE after the lines idle high.
- With `PS2_TX_TIMEOUT_EN`, device never clocks after START:
  - `tx_error` exactly 750_000 cycles after SEND entry.
  - Both `oe`=0 from that cycle.
- `rst` pulsed during data bit 4 of 0xFF: both `oe`=0 and `tx_ready`=1 the next cycle, no pulse. A second request then sends 0xFF correctly.
- `tx_valid` held high with a new byte during a frame: ignored. The first byte completes, then the new byte is accepted in the IDLE cycle after `tx_done`.
